osecpu_fetch_unit: RTL and testbench
====================================

Name: osecpu_fetch_unit

Overview:
Parametrised instruction fetch sequencer for the OSECPU core, separated out from the top-level state machine. It drives the instruction-memory read address and waits a configurable read latency. It assembles one- or two-word instructions, where an opcode-selected instruction carries a trailing 32-bit immediate word. The assembled instruction goes to decode over a valid/ready handshake. It supports branch redirection and exports the PC for the 7-segment debug display.

Parameters:
PC_WIDTH, 16, width of pc, mem_addr, instr_pc and jump_addr
INSTR_WIDTH, 32, width of one memory word; the opcode is bits [INSTR_WIDTH-1:INSTR_WIDTH-8]
MEM_LATENCY, 1, memory read latency in cycles, >=1; the memory samples the address one edge after it changes and returns data MEM_LATENCY edges later
RESET_PC, 0, fetch address after reset
LONG_OPCODE, 8'h02, opcode of two-word instructions (LIMM with imm32)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
mem_addr  out  PC_WIDTH  registered read address to instruction memory
mem_data  in  INSTR_WIDTH  read data from instruction memory
instr_valid  out  1  instr0/instr1/instr_pc/instr_long hold a complete instruction
instr_ready  in  1  decode accepts the instruction
instr0  out  INSTR_WIDTH  first word (opcode and operands)
instr1  out  INSTR_WIDTH  second word; 0 for one-word instructions
instr_long  out  1  1 when instr1 is meaningful
instr_pc  out  PC_WIDTH  address of instr0
jump_valid  in  1  redirect request
jump_addr  in  PC_WIDTH  redirect target
pc  out  PC_WIDTH  next fetch address (debug display)

Behaviour:
- Reset (asynchronous):
  - pc=mem_addr=RESET_PC; instr_valid=0; instr0=instr1=0; instr_long=0; instr_pc=0.
  - Latency counter=0; state=FETCH0.
  - Reset mid-fetch discards all partial state.
- States: FETCH0 -> (FETCH1) -> DELIVER -> FETCH0.
- FETCH0:
  - mem_addr=pc is held for MEM_LATENCY+1 cycles, counted by a counter cleared on state entry.
  - At the end of the last cycle: instr0<=mem_data, instr_pc<=pc, pc<=pc+1.
  - If opcode==LONG_OPCODE, go to FETCH1 with mem_addr<=pc+1. Otherwise instr1<=0, instr_long<=0, and go to DELIVER.
- FETCH1:
  - The same latency rule applies.
  - At the end: instr1<=mem_data, instr_long<=1, pc<=pc+1, go to DELIVER.
- DELIVER:
  - instr_valid=1; all instr_* outputs are stable until instr_valid&&instr_ready.
  - On that handshake edge: instr_valid<=0, go to FETCH0, and mem_addr<=pc.
  - ready may be held low indefinitely without change.
- Latency and throughput:
  - One-word instruction: instr_valid is high MEM_LATENCY+1 cycles after the first FETCH0 cycle.
  - With ready held at 1: one instruction per MEM_LATENCY+2 cycles (one-word) or 2*MEM_LATENCY+3 cycles (two-word).
- pc arithmetic is modulo 2^PC_WIDTH: all-ones+1 wraps to 0. A long instruction at the top address takes its instr1 from address 0.
- jump_valid, sampled at a clock edge in any state, has priority over fetch progress:
  - pc<=jump_addr, mem_addr<=jump_addr, counter cleared, state<=FETCH0, instr_valid<=0.
  - Any partially fetched word is discarded.
- jump_valid together with instr_valid&&instr_ready in the same cycle: the handshake completes (the instruction is consumed exactly once) and the jump is also applied.
- jump_valid held for several cycles: each edge reapplies the redirect. Fetching starts after the last one.
- mem_data is sampled only on the capture edge; its value at any other time is ignored.

Test Plan:
1. MEM_LATENCY=1, mem[0]=32'h01_041000, mem[1]=32'h01_082000, instr_ready=1 after reset:
   - Required: instr_valid rises in cycle 2 with instr0=32'h01041000, instr_pc=0, instr_long=0.
   - Required: the second instruction is valid 3 cycles later with instr_pc=1.
2. mem[0]=32'h02_040000, mem[1]=32'hDEADBEEF:
   - Required: one handshake with instr0=32'h02040000, instr1=32'hDEADBEEF, instr_long=1.
   - Required: pc=2 afterward; the next instr_pc=2.
3. instr_ready=0 for 10 cycles while valid:
   - Required: outputs are unchanged, mem_addr holds, and exactly one handshake occurs when ready rises.
4. jump_valid=1, jump_addr=16'h0040 asserted in FETCH1 of a long instruction:
   - Required: no instruction is delivered for the partial fetch.
   - Required: the next valid has instr_pc=16'h0040.
   - Repeat the test with the jump coincident with a handshake: the instruction is consumed once, then the fetch is at 16'h0040.
5. RESET_PC=16'hFFFF, mem[16'hFFFF]=long opcode, mem[0]=32'h12345678:
   - Required: instr1=32'h12345678, and pc wraps to 1.
6. MEM_LATENCY=3; assert reset mid-FETCH0:
   - Required: instr_valid drops immediately, and pc=mem_addr=RESET_PC.
   - Required: the first valid arrives 4 cycles after reset release, with the correct word.

Source files
------------

// File: rtl/osecpu_fetch_unit.sv
// OSECPU instruction fetch sequencer: fetches one- or two-word instructions from
// a fixed-latency memory and hands them to decode over a valid/ready handshake.
module osecpu_fetch_unit #(
    parameter int                    PC_WIDTH    = 16,
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    MEM_LATENCY = 1,
    parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0,
    parameter logic [7:0]            LONG_OPCODE = 8'h02
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [PC_WIDTH-1:0]    mem_addr,
    input  logic [INSTR_WIDTH-1:0] mem_data,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr0,
    output logic [INSTR_WIDTH-1:0] instr1,
    output logic                   instr_long,
    output logic [PC_WIDTH-1:0]    instr_pc,
    input  logic                   jump_valid,
    input  logic [PC_WIDTH-1:0]    jump_addr,
    output logic [PC_WIDTH-1:0]    pc
);

    localparam int CW = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY);

    typedef enum logic [1:0] {
        FETCH0  = 2'd0,
        FETCH1  = 2'd1,
        DELIVER = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [PC_WIDTH-1:0]    addr_q, addr_d;
    logic                   valid_q, valid_d;
    logic [INSTR_WIDTH-1:0] instr0_q, instr0_d;
    logic [INSTR_WIDTH-1:0] instr1_q, instr1_d;
    logic                   long_q, long_d;
    logic [PC_WIDTH-1:0]    ipc_q, ipc_d;

    logic                   capture;
    logic [PC_WIDTH-1:0]    pc_inc;

    // Address has been held MEM_LATENCY+1 cycles once the counter reaches its last value.
    assign capture = (cnt_q == CNT_LAST);
    assign pc_inc  = pc_q + PC_WIDTH'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        valid_d  = valid_q;
        instr0_d = instr0_q;
        instr1_d = instr1_q;
        long_d   = long_q;
        ipc_d    = ipc_q;

        if (jump_valid) begin
            // Redirect wins over any fetch progress; a pending handshake still completes.
            state_d = FETCH0;
            cnt_d   = '0;
            pc_d    = jump_addr;
            addr_d  = jump_addr;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                FETCH0: begin
                    if (capture) begin
                        cnt_d    = '0;
                        instr0_d = mem_data;
                        ipc_d    = pc_q;
                        pc_d     = pc_inc;
                        if (mem_data[INSTR_WIDTH-1 -: 8] == LONG_OPCODE) begin
                            state_d = FETCH1;
                            addr_d  = pc_inc;
                        end else begin
                            state_d  = DELIVER;
                            instr1_d = '0;
                            long_d   = 1'b0;
                            valid_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                FETCH1: begin
                    if (capture) begin
                        cnt_d    = '0;
                        instr1_d = mem_data;
                        long_d   = 1'b1;
                        pc_d     = pc_inc;
                        state_d  = DELIVER;
                        valid_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DELIVER: begin
                    if (instr_ready) begin
                        state_d = FETCH0;
                        cnt_d   = '0;
                        valid_d = 1'b0;
                        addr_d  = pc_q;
                    end
                end
                default: begin
                    state_d = FETCH0;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    addr_d  = pc_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= FETCH0;
            cnt_q    <= '0;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            valid_q  <= 1'b0;
            instr0_q <= '0;
            instr1_q <= '0;
            long_q   <= 1'b0;
            ipc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            valid_q  <= valid_d;
            instr0_q <= instr0_d;
            instr1_q <= instr1_d;
            long_q   <= long_d;
            ipc_q    <= ipc_d;
        end
    end

    assign mem_addr    = addr_q;
    assign pc          = pc_q;
    assign instr_valid = valid_q;
    assign instr0      = instr0_q;
    assign instr1      = instr1_q;
    assign instr_long  = long_q;
    assign instr_pc    = ipc_q;

endmodule

// File: tb/tb_osecpu_fetch_unit.sv
// Directed bench for osecpu_fetch_unit: three instances cover latency 1, top-of-memory
// wrap with RESET_PC=FFFF, and latency 3 with asynchronous reset mid-fetch.
module tb_osecpu_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- instance A: latency 1, RESET_PC 0 ----------------
    logic        rst_a = 1'b1, rdy_a = 1'b0, jv_a = 1'b0;
    logic [15:0] ja_a = '0, addr_a, pc_a, ipc_a;
    logic [31:0] md_a = '0, i0_a, i1_a;
    logic        vld_a, long_a;

    osecpu_fetch_unit #(.MEM_LATENCY(1), .RESET_PC(16'h0000)) dut_a (
        .clk(clk), .reset(rst_a), .mem_addr(addr_a), .mem_data(md_a),
        .instr_valid(vld_a), .instr_ready(rdy_a), .instr0(i0_a), .instr1(i1_a),
        .instr_long(long_a), .instr_pc(ipc_a), .jump_valid(jv_a), .jump_addr(ja_a),
        .pc(pc_a));

    function automatic logic [31:0] mem_a(input logic [15:0] a);
        case (a)
            16'h0000: mem_a = 32'h01041000;
            16'h0001: mem_a = 32'h01082000;
            16'h0002: mem_a = 32'h02040000;
            16'h0003: mem_a = 32'hDEADBEEF;
            16'h0004: mem_a = 32'h01000004;
            16'h0005: mem_a = 32'h02000005;
            16'h0006: mem_a = 32'hCAFEF00D;
            16'h0040: mem_a = 32'h01000040;
            default:  mem_a = 32'h0F0F0F0F;
        endcase
    endfunction
    always @(posedge clk) md_a <= mem_a(addr_a);

    int hs_a = 0;
    always @(posedge clk) if (!rst_a && vld_a && rdy_a) hs_a <= hs_a + 1;

    // ---------------- instance B: latency 1, RESET_PC FFFF ----------------
    logic        rst_b = 1'b1;
    logic        rdy_b = 1'b0;
    logic [15:0] addr_b, pc_b, ipc_b;
    logic [31:0] md_b = '0, i0_b, i1_b;
    logic        vld_b, long_b;

    osecpu_fetch_unit #(.MEM_LATENCY(1), .RESET_PC(16'hFFFF)) dut_b (
        .clk(clk), .reset(rst_b), .mem_addr(addr_b), .mem_data(md_b),
        .instr_valid(vld_b), .instr_ready(rdy_b), .instr0(i0_b), .instr1(i1_b),
        .instr_long(long_b), .instr_pc(ipc_b), .jump_valid(1'b0), .jump_addr(16'h0000),
        .pc(pc_b));

    function automatic logic [31:0] mem_b(input logic [15:0] a);
        case (a)
            16'hFFFF: mem_b = 32'h02000000;
            16'h0000: mem_b = 32'h12345678;
            default:  mem_b = 32'h0F0F0F0F;
        endcase
    endfunction
    always @(posedge clk) md_b <= mem_b(addr_b);

    // ---------------- instance C: latency 3, RESET_PC 0 ----------------
    logic        rst_c = 1'b1, rdy_c = 1'b0;
    logic [15:0] addr_c, pc_c, ipc_c;
    logic [31:0] i0_c, i1_c;
    logic [31:0] p0_c = '0, p1_c = '0, p2_c = '0;
    logic        vld_c, long_c;

    osecpu_fetch_unit #(.MEM_LATENCY(3), .RESET_PC(16'h0000)) dut_c (
        .clk(clk), .reset(rst_c), .mem_addr(addr_c), .mem_data(p2_c),
        .instr_valid(vld_c), .instr_ready(rdy_c), .instr0(i0_c), .instr1(i1_c),
        .instr_long(long_c), .instr_pc(ipc_c), .jump_valid(1'b0), .jump_addr(16'h0000),
        .pc(pc_c));

    function automatic logic [31:0] mem_c(input logic [15:0] a);
        case (a)
            16'h0000: mem_c = 32'h01000C00;
            16'h0001: mem_c = 32'h01000C01;
            default:  mem_c = 32'h0F0F0F0F;
        endcase
    endfunction
    always @(posedge clk) begin
        p0_c <= mem_c(addr_c);
        p1_c <= p0_c;
        p2_c <= p1_c;
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rdy;
        logic        jv;
        logic [15:0] ja;
        logic        ev;
        logic [15:0] eaddr;
        logic [15:0] epc;
        logic [31:0] ei0;
        logic [31:0] ei1;
        logic        el;
        logic [15:0] eipc;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic rdy, input logic jv, input logic [15:0] ja,
                                input logic ev, input logic [15:0] eaddr, input logic [15:0] epc,
                                input logic [31:0] ei0, input logic [31:0] ei1,
                                input logic el, input logic [15:0] eipc);
        vec_t v;
        v.rdy = rdy; v.jv = jv; v.ja = ja; v.ev = ev; v.eaddr = eaddr; v.epc = epc;
        v.ei0 = ei0; v.ei1 = ei1; v.el = el; v.eipc = eipc;
        return v;
    endfunction

    // Cycles from reset release (or now) until instr_valid of the selected instance.
    task automatic wait_valid(input int sel, output int n);
        n = 0;
        while (n < 40) begin
            if ((sel == 1 && vld_b) || (sel == 2 && vld_c)) return;
            @(posedge clk); @(negedge clk);
            n++;
        end
    endtask

    int n;

    initial begin
        // one-word fetches, then one long, at period 3 and 5
        tv.push_back(mk(1,0,16'h0, 0,16'h0,16'h0, 0,0,0,0));
        tv.push_back(mk(1,0,16'h0, 0,16'h0,16'h0, 0,0,0,0));
        tv.push_back(mk(1,0,16'h0, 1,16'h0,16'h1, 32'h01041000,0,0,16'h0));
        tv.push_back(mk(1,0,16'h0, 0,16'h1,16'h1, 0,0,0,0));
        tv.push_back(mk(1,0,16'h0, 0,16'h1,16'h1, 0,0,0,0));
        tv.push_back(mk(1,0,16'h0, 1,16'h1,16'h2, 32'h01082000,0,0,16'h1));
        tv.push_back(mk(1,0,16'h0, 0,16'h2,16'h2, 0,0,0,0));
        tv.push_back(mk(1,0,16'h0, 0,16'h2,16'h2, 0,0,0,0));
        tv.push_back(mk(1,0,16'h0, 0,16'h3,16'h3, 0,0,0,0));
        tv.push_back(mk(1,0,16'h0, 0,16'h3,16'h3, 0,0,0,0));
        tv.push_back(mk(1,0,16'h0, 1,16'h3,16'h4, 32'h02040000,32'hDEADBEEF,1,16'h2));
        tv.push_back(mk(1,0,16'h0, 0,16'h4,16'h4, 0,0,0,0));
        tv.push_back(mk(1,0,16'h0, 0,16'h4,16'h4, 0,0,0,0));
        // decode stalls for 10 cycles, then accepts
        for (int i = 0; i < 10; i++)
            tv.push_back(mk(0,0,16'h0, 1,16'h4,16'h5, 32'h01000004,0,0,16'h4));
        tv.push_back(mk(1,0,16'h0, 1,16'h4,16'h5, 32'h01000004,0,0,16'h4));
        tv.push_back(mk(1,0,16'h0, 0,16'h5,16'h5, 0,0,0,0));
        tv.push_back(mk(1,0,16'h0, 0,16'h5,16'h5, 0,0,0,0));
        // jump during FETCH1 of the long at 5: partial fetch dropped
        tv.push_back(mk(1,1,16'h40, 0,16'h6,16'h6, 0,0,0,0));
        tv.push_back(mk(1,0,16'h0, 0,16'h40,16'h40, 0,0,0,0));
        tv.push_back(mk(1,0,16'h0, 0,16'h40,16'h40, 0,0,0,0));
        // jump coincident with handshake
        tv.push_back(mk(1,1,16'h40, 1,16'h40,16'h41, 32'h01000040,0,0,16'h40));
        tv.push_back(mk(1,0,16'h0, 0,16'h40,16'h40, 0,0,0,0));
        tv.push_back(mk(1,0,16'h0, 0,16'h40,16'h40, 0,0,0,0));
        tv.push_back(mk(0,0,16'h0, 1,16'h40,16'h41, 32'h01000040,0,0,16'h40));
        tv.push_back(mk(0,0,16'h0, 1,16'h40,16'h41, 32'h01000040,0,0,16'h40));

        repeat (3) @(negedge clk);
        chk("a_rst_valid", {31'h0, vld_a}, 32'h0);
        chk("a_rst_pc",    {16'h0, pc_a}, 32'h0);
        chk("a_rst_addr",  {16'h0, addr_a}, 32'h0);
        chk("a_rst_instr0", i0_a, 32'h0);
        chk("b_rst_pc",    {16'h0, pc_b}, 32'h0000FFFF);
        chk("b_rst_addr",  {16'h0, addr_b}, 32'h0000FFFF);

        // ---- instance A table ----
        rst_a = 1'b0;
        for (int i = 0; i < tv.size(); i++) begin
            rdy_a = tv[i].rdy;
            jv_a  = tv[i].jv;
            ja_a  = tv[i].ja;
            chk($sformatf("a_valid[%0d]", i), {31'h0, vld_a}, {31'h0, tv[i].ev});
            chk($sformatf("a_addr[%0d]", i),  {16'h0, addr_a}, {16'h0, tv[i].eaddr});
            chk($sformatf("a_pc[%0d]", i),    {16'h0, pc_a}, {16'h0, tv[i].epc});
            if (tv[i].ev) begin
                chk($sformatf("a_instr0[%0d]", i), i0_a, tv[i].ei0);
                chk($sformatf("a_instr1[%0d]", i), i1_a, tv[i].ei1);
                chk($sformatf("a_long[%0d]", i),   {31'h0, long_a}, {31'h0, tv[i].el});
                chk($sformatf("a_ipc[%0d]", i),    {16'h0, ipc_a}, {16'h0, tv[i].eipc});
            end
            @(posedge clk); @(negedge clk);
        end
        chk("a_handshakes", hs_a, 32'd5);
        rdy_a = 1'b0; jv_a = 1'b0;

        // ---- instance B: long instruction at top of memory wraps ----
        rst_b = 1'b0;
        wait_valid(1, n);
        chk("b_latency", n, 32'd4);
        chk("b_instr0", i0_b, 32'h02000000);
        chk("b_instr1", i1_b, 32'h12345678);
        chk("b_long",   {31'h0, long_b}, 32'h1);
        chk("b_ipc",    {16'h0, ipc_b}, 32'h0000FFFF);
        chk("b_pc",     {16'h0, pc_b}, 32'h1);

        // ---- instance C: latency 3, reset mid-fetch ----
        rst_c = 1'b0;
        wait_valid(2, n);
        chk("c_latency0", n, 32'd4);
        chk("c_instr0_0", i0_c, 32'h01000C00);
        rdy_c = 1'b1;
        @(posedge clk); @(negedge clk);
        rdy_c = 1'b0;
        chk("c_fetch_addr", {16'h0, addr_c}, 32'h1);
        @(posedge clk); @(negedge clk);
        #2 rst_c = 1'b1;
        #1;
        chk("c_midrst_valid", {31'h0, vld_c}, 32'h0);
        chk("c_midrst_pc",    {16'h0, pc_c}, 32'h0);
        chk("c_midrst_addr",  {16'h0, addr_c}, 32'h0);
        @(negedge clk);
        rst_c = 1'b0;
        wait_valid(2, n);
        chk("c_latency1", n, 32'd4);
        chk("c_instr0_1", i0_c, 32'h01000C00);
        chk("c_ipc_1",    {16'h0, ipc_c}, 32'h0);
        // reset while an instruction is being offered drops valid without an edge
        #2 rst_c = 1'b1;
        #1;
        chk("c_rst_drop_valid", {31'h0, vld_c}, 32'h0);
        chk("c_rst_drop_instr0", i0_c, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
